// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: on-chip key expansion (one round key per cycle)
// and a single shared inverse-round datapath (one round per cycle), valid/ready on both sides.
module aes128_decrypt_iter (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_key,
    input  logic [127:0] IN_KEY,
    output logic         key_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] IN_DATA,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] OUT_DATA,
    output logic         busy
);

    typedef enum logic [2:0] {NOKEY, KEYGEN, READY, DECRYPT, HOLD} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    state_t       state;
    logic [127:0] rk [0:10];
    logic [3:0]   kcnt;
    logic [3:0]   rnd;
    logic [127:0] state_reg;
    logic [127:0] next_key;
    logic [127:0] round_out;

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
        return INV_SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = prev;
        t  = {sub_byte(w3[23:16]), sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])}
             ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            m9[i] = xtime(x4[i]) ^ a[i];
            mb[i] = xtime(x4[i]) ^ x2[i] ^ a[i];
            md[i] = xtime(x4[i]) ^ x4[i] ^ a[i];
            me[i] = xtime(x4[i]) ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Byte (row r, column c) sits at index 4c+r; InvShiftRows pulls from column c-r.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        logic [127:0] m;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] = inv_sub_byte(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        t = t ^ k;
        for (int c = 0; c < 4; c++)
            m[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
        return last ? t : m;
    endfunction

    // NOTE: both results are assigned unconditionally on every evaluation, so no latch is inferred.
    always_comb begin
        next_key  = expand(rk[kcnt - 4'd1], rcon(kcnt));
        round_out = inv_round(state_reg, rk[rnd], rnd == 4'd0);
    end

    assign OUT_DATA = out_valid ? state_reg : '0;

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state     <= NOKEY;
            // NOTE: the round-key file is a small flop array and is cleared so no key survives a reset.
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
            kcnt      <= '0;
            rnd       <= '0;
            state_reg <= '0;
            key_ready <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                NOKEY, READY: begin
                    if (load_key) begin
                        rk[0]     <= IN_KEY;
                        kcnt      <= 4'd1;
                        key_ready <= 1'b0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= KEYGEN;
                    end else if (state == READY && in_valid) begin
                        state_reg <= IN_DATA ^ rk[10];
                        rnd       <= 4'd9;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DECRYPT;
                    end
                end
                KEYGEN: begin
                    rk[kcnt] <= next_key;
                    kcnt     <= kcnt + 4'd1;
                    if (kcnt == 4'd10) begin
                        key_ready <= 1'b1;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= READY;
                    end
                end
                DECRYPT: begin
                    state_reg <= round_out;
                    rnd       <= rnd - 4'd1;
                    if (rnd == 4'd0) begin
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= READY;
                    end
                end
                default: state <= NOKEY;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter using the FIPS-197 appendix B and C.1 vectors.
module tb_aes128_decrypt_iter;

    localparam logic [127:0] K1      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] CT1     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CT2     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2     = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         resetn;
    logic         load_key;
    logic [127:0] IN_KEY;
    logic         key_ready;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] IN_DATA;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] OUT_DATA;
    logic         busy;

    int           n_vec = 0;
    int           n_err = 0;
    int           n_acc = 0;
    int           cyc = 0;
    logic [127:0] exp_q[$];
    int           acc_cyc[$];
    logic [127:0] cur_exp;

    aes128_decrypt_iter dut (
        .clk(clk), .resetn(resetn), .load_key(load_key), .IN_KEY(IN_KEY),
        .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready), .IN_DATA(IN_DATA),
        .out_valid(out_valid), .out_ready(out_ready), .OUT_DATA(OUT_DATA), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_word(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Accept model: a block is taken when in_valid meets in_ready, unless load_key wins that edge.
    always @(negedge clk) begin
        if (!resetn && in_valid && in_ready && !load_key) begin
            exp_q.push_back(cur_exp);
            acc_cyc.push_back(cyc);
            n_acc <= n_acc + 1;
        end
    end

    always @(negedge clk) begin
        if (!resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) check_word("out_unexpected", OUT_DATA, 128'hx);
            else check_word("out_data", OUT_DATA, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_key(output int lat);
        lat = 0;
        while (!key_ready && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic load_and_wait(input logic [127:0] k, output int lat);
        IN_KEY   = k;
        load_key = 1'b1;
        tick();
        load_key = 1'b0;
        wait_key(lat);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Returns just after the accept edge.
    task automatic send(input logic [127:0] ct, input logic [127:0] pt, output logic ok);
        int base;
        int k;
        base     = n_acc;
        k        = 0;
        cur_exp  = pt;
        IN_DATA  = ct;
        in_valid = 1'b1;
        tick();
        while (n_acc == base && k < 40) begin
            tick();
            k++;
        end
        in_valid = 1'b0;
        ok       = (n_acc != base);
    endtask

    initial begin
        int   lat;
        int   base;
        int   k;
        logic ok;
        logic seen;

        resetn = 1'b1; load_key = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        IN_KEY = '0; IN_DATA = '0; cur_exp = '0;
        repeat (2) tick();
        check_bit("rst_key_ready", key_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_word("rst_out_data", OUT_DATA, '0);
        check_word("rst_rk10", dut.rk[10], '0);
        resetn = 1'b0;
        tick();

        // Key expansion latency and last round key
        load_and_wait(K1, lat);
        check_int("t1_key_latency", lat, 10);
        check_word("t1_rk10", dut.rk[10], K1_RK10);
        check_bit("t1_in_ready", in_ready, 1'b1);

        // Single block with the consumer always ready
        send(CT1, PT1, ok);
        check_bit("t2_accept", ok, 1'b1);
        check_bit("t2_busy", busy, 1'b1);
        wait_out(lat);
        check_int("t2_latency", lat, 10);
        tick();
        check_bit("t2_pulse_end", out_valid, 1'b0);
        check_word("t2_out_idle", OUT_DATA, '0);
        check_bit("t2_in_ready_back", in_ready, 1'b1);

        // New key loaded in READY together with in_valid: load wins
        base = n_acc; IN_DATA = CT2; cur_exp = PT2; in_valid = 1'b1;
        IN_KEY = K2; load_key = 1'b1;
        tick();
        load_key = 1'b0; in_valid = 1'b0;
        check_int("t3_no_accept_on_load", n_acc, base);
        check_bit("t3_in_ready_drop", in_ready, 1'b0);
        wait_key(lat);
        check_int("t3_key_latency", lat, 10);
        check_word("t3_rk10", dut.rk[10], K2_RK10);

        // Back-pressure: plaintext held for 5 cycles, load_key in HOLD ignored
        out_ready = 1'b0;
        send(CT2, PT2, ok);
        check_bit("t3_accept", ok, 1'b1);
        wait_out(lat);
        check_int("t3_latency", lat, 10);
        for (int i = 0; i < 5; i++) begin
            check_bit("t3_hold_valid", out_valid, 1'b1);
            check_word("t3_hold_data", OUT_DATA, PT2);
            check_bit("t3_hold_in_ready", in_ready, 1'b0);
            if (i == 1) begin
                IN_KEY   = K1;
                load_key = 1'b1;
            end
            tick();
            load_key = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        check_bit("t3_release_valid", out_valid, 1'b0);
        check_word("t3_release_data", OUT_DATA, '0);
        check_bit("t3_release_in_ready", in_ready, 1'b1);
        check_word("t3_rk10_kept", dut.rk[10], K2_RK10);

        // Reset in the middle of a decrypt
        load_and_wait(K1, lat);
        check_int("t5_key_latency", lat, 10);
        send(CT1, PT1, ok);
        check_bit("t5_accept", ok, 1'b1);
        repeat (5) tick();
        resetn = 1'b1;
        #1;
        check_bit("t5_key_ready", key_ready, 1'b0);
        check_bit("t5_out_valid", out_valid, 1'b0);
        check_bit("t5_busy", busy, 1'b0);
        check_bit("t5_in_ready", in_ready, 1'b0);
        check_word("t5_rk10_cleared", dut.rk[10], '0);
        exp_q.delete();
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_bit("t5_no_output", seen, 1'b0);
        resetn = 1'b0;
        tick();

        // in_valid held through NOKEY and KEYGEN: accepted only once keys are ready
        base = n_acc; IN_DATA = CT1; cur_exp = PT1; in_valid = 1'b1;
        repeat (3) begin
            tick();
            check_bit("t4_nokey_in_ready", in_ready, 1'b0);
        end
        load_and_wait(K1, lat);
        check_int("t4_key_latency", lat, 10);
        check_int("t4_no_accept_keygen", n_acc, base);
        tick();
        in_valid = 1'b0;
        check_int("t4_accept", n_acc, base + 1);
        wait_out(lat);
        check_int("t4_latency", lat, 10);
        tick();
        check_bit("t4_pulse_end", out_valid, 1'b0);

        // Back-to-back blocks, load_key pulsed mid-decrypt
        base = n_acc; k = 0; acc_cyc.delete();
        IN_DATA = CT1; cur_exp = PT1; IN_KEY = K2; in_valid = 1'b1;
        while (n_acc < base + 2 && k < 80) begin
            load_key = (k == 5);
            tick();
            k++;
        end
        load_key = 1'b0; in_valid = 1'b0;
        check_int("t6_accepts", n_acc, base + 2);
        if (acc_cyc.size() == 2) check_int("t6_spacing", acc_cyc[1] - acc_cyc[0], 12);
        wait_out(lat);
        check_int("t6_latency", lat, 10);
        tick();
        check_bit("t6_pulse_end", out_valid, 1'b0);
        check_word("t6_rk10_kept", dut.rk[10], K1_RK10);
        check_bit("t6_key_ready", key_ready, 1'b1);

        repeat (2) tick();
        check_int("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
